// File: rtl/tt_um_jimktrains_vslc_stack_shifter.sv
// ---------------------------------------------------------------------------
// tt_um_jimktrains_vslc_stack_shifter
//
// Output stage for the VSLC core. On each scan-cycle trigger it captures the
// executor's stack/output word. It shifts that word MSB-first into an external
// 74HC595-style chain, then pulses the storage latch so that all external
// outputs update together.
//
// Optional feature macro: VSLC_STACK_SHIFT_READBACK_EN
//   When defined, the bit returned from the end of the chain (sr_din) is
//   sampled on every SCK rising edge. The assembled word is published on
//   readback in the done cycle.
//   When undefined, readback is tied to 0 and sr_din is ignored.
//   The port list is the same in both builds.
//
// Ports
//   clk       in   system clock, posedge
//   rst       in   synchronous active-high reset
//   clk_div   in   [7:0] SCK phase length minus one, captured at transfer start
//   trigger   in   scan-cycle clock; a rising edge requests a transfer
//   data_in   in   [WIDTH-1:0] word to ship, captured on the accepted edge
//   sr_din    in   serial data returned from the end of the chain
//   sr_data   out  serial data to the chain
//   sr_clk    out  shift clock to the chain
//   sr_latch  out  storage-register latch strobe
//   busy      out  transfer in progress (SETUP/HIGH/LATCH)
//   done      out  single-cycle pulse on the last LATCH cycle
//   overrun   out  sticky; a trigger edge arrived while busy
//   readback  out  [WIDTH-1:0] last word shifted out of the chain
//
// Handshake: trigger is a request with no ready. An edge is accepted only in
// IDLE. An edge in any other state is dropped and recorded in overrun. This
// includes an edge in the done cycle.
// ---------------------------------------------------------------------------
module tt_um_jimktrains_vslc_stack_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       clk_div,
  input  logic             trigger,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr_din,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [WIDTH-1:0] readback
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             trig_q;
  logic             trig_prev;
  logic             trig_edge;
  logic             phase_end;
  logic [WIDTH-1:0] shadow;
  logic [7:0]       div;
  logic [7:0]       ph_cnt;
  logic [CNT_W-1:0] bit_cnt;

  assign trig_edge = trig_q & ~trig_prev;
  // Every phase (SETUP, HIGH, LATCH) lasts div+1 cycles.
  assign phase_end = (ph_cnt == div);

  always_comb begin
    state_next = state;
    sr_clk     = 1'b0;
    sr_data    = 1'b0;
    sr_latch   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (trig_edge) state_next = SETUP;
      end
      SETUP: begin
        sr_data = shadow[WIDTH-1];
        if (phase_end) state_next = HIGH;
      end
      HIGH: begin
        sr_clk  = 1'b1;
        // shadow only shifts when leaving HIGH, so the data bit holds across the rise.
        sr_data = shadow[WIDTH-1];
        if (phase_end) state_next = (bit_cnt == '0) ? LATCH : SETUP;
      end
      LATCH: begin
        sr_latch = 1'b1;
        if (phase_end) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      trig_prev <= 1'b0;
      overrun   <= 1'b0;
      shadow    <= '0;
      div       <= '0;
      ph_cnt    <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_next;
      trig_q    <= trigger;
      trig_prev <= trig_q;
      if (trig_edge && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            shadow  <= data_in;
            div     <= clk_div;
            bit_cnt <= CNT_W'(WIDTH - 1);
            ph_cnt  <= '0;
          end
        end
        default: begin
          // ph_cnt restarts at each phase boundary, so it never runs past div.
          if (phase_end) ph_cnt <= '0;
          else           ph_cnt <= ph_cnt + 8'd1;
          if ((state == HIGH) && phase_end) begin
            shadow <= {shadow[WIDTH-2:0], 1'b0};
            if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
          end
        end
      endcase
    end
  end

`ifdef VSLC_STACK_SHIFT_READBACK_EN
  logic [WIDTH-1:0] rb_shift;

  // Sample on the SETUP->HIGH transition. That is the chain's SCK rising edge,
  // so the bit taken is the chain tail before it shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_shift <= '0;
      readback <= '0;
    end else begin
      if ((state == SETUP) && phase_end) rb_shift <= {rb_shift[WIDTH-2:0], sr_din};
      if (done) readback <= rb_shift;
    end
  end
`else
  logic unused_sr_din;
  assign unused_sr_din = sr_din;
  assign readback      = '0;
`endif

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_stack_shifter.sv
module tb_tt_um_jimktrains_vslc_stack_shifter;
  localparam int W = 16;

  // ---- clock / reset ----
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   clk_div;
  logic         trigger;
  logic [W-1:0] data_in;
  logic         sr_din;
  logic         sr_data, sr_clk, sr_latch, busy, done, overrun;
  logic [W-1:0] readback;

  int n_cmp = 0;
  int n_err = 0;

  tt_um_jimktrains_vslc_stack_shifter #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .trigger(trigger),
    .data_in(data_in), .sr_din(sr_din), .sr_data(sr_data), .sr_clk(sr_clk),
    .sr_latch(sr_latch), .busy(busy), .done(done), .overrun(overrun),
    .readback(readback)
  );

  // ---- external 16-bit chain model: shifts on each sr_clk rise ----
  logic [W-1:0] chain;
  logic         chain_load;
  logic         sclk_prev;
  assign sr_din = chain[W-1];
  always @(posedge clk) begin
    sclk_prev <= sr_clk;
    if (chain_load) chain <= 16'h1234;
    else if (sr_clk && !sclk_prev) chain <= {chain[W-2:0], sr_data};
  end

  // ---- scoreboard ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [7:0]  div;
    logic [15:0] mid_data;
    logic [7:0]  mid_div;
    int          retrig_at;
    logic [15:0] exp_word;
    int          exp_done_cyc;
    int          exp_latch;
    int          exp_high;
    logic        exp_ovr;
    logic        exp_busy_after;
  } vec_t;

  vec_t vecs[7];

  // One transfer; cycle 1 is the first sample in which SETUP is expected.
  task automatic run_row(input vec_t v, input bit do_rst, input string tag);
    logic [15:0] word;
    int rises, high_cnt, latch_cnt, done_cyc;
    bit seen_done, prev;
    word = '0; rises = 0; high_cnt = 0; latch_cnt = 0; done_cyc = 0;
    seen_done = 0; prev = 0;
    if (do_rst) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
    data_in = v.data;
    clk_div = v.div;
    trigger = 1'b1;
    step();
    check({tag, " busy_before_accept"}, 32'(busy), 32'd0);
    step();
    for (int cyc = 1; cyc <= v.exp_done_cyc + 4; cyc++) begin
      if (cyc == 1) begin
        check({tag, " busy_cyc1"}, 32'(busy), 32'd1);
        check({tag, " sr_clk_cyc1"}, 32'(sr_clk), 32'd0);
        check({tag, " sr_data_cyc1"}, 32'(sr_data), 32'(v.exp_word[15]));
        trigger = 1'b0;
      end
      if (!seen_done) begin
        if (sr_clk) high_cnt++;
        if (sr_clk && !prev) begin
          word = {word[14:0], sr_data};
          rises++;
        end
        if (sr_latch) latch_cnt++;
        if (done) begin
          seen_done = 1;
          done_cyc  = cyc;
        end
      end else if (cyc == done_cyc + 1) begin
        check({tag, " busy_after_done"}, 32'(busy), 32'd0);
      end
      prev = sr_clk;
      if (cyc == 5) begin
        data_in = v.mid_data;
        clk_div = v.mid_div;
      end
      if (v.retrig_at != 0 && cyc == v.retrig_at)     trigger = 1'b1;
      if (v.retrig_at != 0 && cyc == v.retrig_at + 2) trigger = 1'b0;
      if (cyc < v.exp_done_cyc + 4) step();
    end
    check({tag, " rises"}, 32'(rises), 32'd16);
    check({tag, " word"}, 32'(word), 32'(v.exp_word));
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
    check({tag, " latch_len"}, 32'(latch_cnt), 32'(v.exp_latch));
    check({tag, " sck_high_total"}, 32'(high_cnt), 32'(v.exp_high));
    check({tag, " overrun"}, 32'(overrun), 32'(v.exp_ovr));
    check({tag, " busy_end"}, 32'(busy), 32'(v.exp_busy_after));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rise_cnt, lat_cnt;
    bit prev_ck;
    vec_t v;

    //            data      div    mid_data  mid_div retrig word     done  latch high  ovr   busy_after
    vecs[0] = '{16'hA5C3, 8'd0,   16'hA5C3, 8'd0,   0,  16'hA5C3, 33,   1,    16,   1'b0, 1'b0};
    vecs[1] = '{16'h8001, 8'd3,   16'hFFFF, 8'd0,   0,  16'h8001, 132,  4,    64,   1'b0, 1'b0};
    vecs[2] = '{16'h5A3C, 8'd1,   16'h5A3C, 8'd1,   10, 16'h5A3C, 66,   2,    32,   1'b1, 1'b0};
    vecs[3] = '{16'h0001, 8'd255, 16'h0001, 8'd255, 0,  16'h0001, 8448, 256,  4096, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFE, 8'd0,   16'h7FFE, 8'd0,   32, 16'h7FFE, 33,   1,    16,   1'b1, 1'b0};
    vecs[5] = '{16'hC0DE, 8'd0,   16'hC0DE, 8'd0,   34, 16'hC0DE, 33,   1,    16,   1'b0, 1'b1};
    vecs[6] = '{16'h1357, 8'd0,   16'h1357, 8'd0,   31, 16'h1357, 33,   1,    16,   1'b1, 1'b0};

    chain_load = 1'b1;
    rst        = 1'b1;
    trigger    = 1'b1;
    data_in    = 16'h8001;
    clk_div    = 8'd0;

    // Reset with trigger held high: all outputs low.
    repeat (3) step();
    check("rst sr_data", 32'(sr_data), 32'd0);
    check("rst sr_clk", 32'(sr_clk), 32'd0);
    check("rst sr_latch", 32'(sr_latch), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    check("rst readback", 32'(readback), 32'd0);
    chain_load = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst busy_c1", 32'(busy), 32'd0);
    step();
    check("post_rst busy_c2", 32'(busy), 32'd1);
    check("post_rst sr_clk_c2", 32'(sr_clk), 32'd0);
    check("post_rst sr_data_c2", 32'(sr_data), 32'd1);
    trigger = 1'b0;
    for (int i = 0; i < 40 && busy; i++) step();
    check("post_rst finished", 32'(busy), 32'd0);

    // Table-driven transfers.
    for (int i = 0; i < 7; i++) run_row(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Reset during HIGH of bit 7: no latch, outputs low, then a fresh transfer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    data_in = 16'hFFFF;
    clk_div = 8'd0;
    trigger = 1'b1;
    step();
    step();
    trigger = 1'b0;
    rise_cnt = 0; lat_cnt = 0; prev_ck = 0;
    for (int i = 0; i < 40; i++) begin
      if (sr_latch) lat_cnt++;
      if (sr_clk && !prev_ck) rise_cnt++;
      prev_ck = sr_clk;
      if (rise_cnt == 9) begin
        rst = 1'b1;
        break;
      end
      step();
    end
    check("midrst reached_bit7", 32'(rise_cnt), 32'd9);
    step();
    rst = 1'b0;
    check("midrst sr_clk", 32'(sr_clk), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst sr_latch", 32'(sr_latch), 32'd0);
    check("midrst sr_data", 32'(sr_data), 32'd0);
    check("midrst latch_never", 32'(lat_cnt), 32'd0);
    v = '{16'h0F0F, 8'd0, 16'h0F0F, 8'd0, 0, 16'h0F0F, 33, 1, 16, 1'b0, 1'b0};
    run_row(v, 1'b0, "after_midrst");

    // Chain readback: chain preloaded with 16'h1234.
    chain_load = 1'b1;
    step();
    chain_load = 1'b0;
    v = '{16'hBEEF, 8'd0, 16'hBEEF, 8'd0, 0, 16'hBEEF, 33, 1, 16, 1'b0, 1'b0};
    run_row(v, 1'b1, "readback_xfer");
    check("chain holds sent word", 32'(chain), 32'h0000BEEF);
`ifdef VSLC_STACK_SHIFT_READBACK_EN
    check("readback value", 32'(readback), 32'h00001234);
    repeat (5) step();
    check("readback held", 32'(readback), 32'h00001234);
`else
    check("readback value", 32'(readback), 32'h00000000);
    repeat (5) step();
    check("readback held", 32'(readback), 32'h00000000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
